spi_slave2axis: RTL and testbench



---
 rtl/spi_slave2axis_if.sv | 13 +
 rtl/spi_slave2axis.sv | 156 +++++++++++++++
 tb/tb_spi_slave2axis.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave2axis_if.sv
// 8-bit AXI-Stream bundle used on both sides of the SPI slave front end.
//   tdata  : byte payload
//   tvalid : payload valid (source -> sink)
//   tready : sink ready    (sink -> source)
// The master modport is the byte source; the slave modport is the byte sink.
interface spi_slave2axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/spi_slave2axis.sv
// SPI slave front end (mode 0, MSB first), oversampled in the aclk domain.
// Received MOSI bytes leave on m_axis; response bytes taken from s_axis are
// shifted out on MISO.
// Ports:
//   aclk, aresetn          : system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi     : asynchronous SPI inputs
//   spi_miso, spi_miso_oe  : registered MISO data and its output enable
//   m_axis (master)        : received bytes
//   s_axis (slave)         : bytes to transmit (one-byte holding register)
//   rx_overflow            : sticky, a received byte was dropped
//   tx_underflow           : sticky, 0x00 was sent for lack of a TX byte
// SYNC_STAGES (2..4) sets the input synchronizer depth.
module spi_slave2axis #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  spi_slave2axis_if.master  m_axis,
  spi_slave2axis_if.slave   s_axis,
  output logic              rx_overflow,
  output logic              tx_underflow
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  // Input synchronizers plus previous-value flops for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   cs_act, cs_fall, sclk_rise, sclk_fall;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_act    = ~cs_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign sclk_rise = cs_act & sclk_s & ~sclk_d;
  assign sclk_fall = cs_act & ~sclk_s & sclk_d;

  // Bit position and RX shifter
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_done;
  logic [DATA_W-1:0] rx_byte;

  assign rx_done = sclk_rise && (bit_cnt == CNT_W'(7));
  assign rx_byte = {rx_shift[DATA_W-2:0], mosi_s};

  // TX holding register and shifter; next-state computed here so MISO can
  // present the new bit in the same cycle the shifter updates.
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic [DATA_W-1:0] hold_data, hold_data_n;
  logic              hold_valid, hold_valid_n;
  logic              tx_load, tx_under_set, s_accept;

  assign tx_load  = cs_fall | (sclk_fall && (bit_cnt == CNT_W'(0)));
  assign s_accept = s_axis.tvalid & s_axis.tready;

  always_comb begin
    tx_shift_n   = tx_shift;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid;
    tx_under_set = 1'b0;
    if (tx_load) begin
      if (hold_valid) begin
        tx_shift_n   = hold_data;
        hold_valid_n = 1'b0;
      end else begin
        tx_shift_n   = '0;
        tx_under_set = 1'b1;
      end
    end else if (sclk_fall) begin
      tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
    end
    // Accept only happens with the hold empty, so it never collides with a
    // load taken from the hold; with an empty-hold load it is kept for later.
    if (s_accept) begin
      hold_data_n  = s_axis.tdata;
      hold_valid_n = 1'b1;
    end
  end

  // Sequential state and registered outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      s_axis.tready <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      rx_overflow   <= 1'b0;
      tx_underflow  <= 1'b0;
    end else begin
      if (!cs_act || cs_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (sclk_rise) begin
        rx_shift <= rx_byte;
      end

      // Output register: a full byte wins over the handshake clear
      if (rx_done && (!m_axis.tvalid || m_axis.tready)) begin
        m_axis.tdata  <= rx_byte;
        m_axis.tvalid <= 1'b1;
      end else begin
        if (rx_done) begin
          rx_overflow <= 1'b1;
        end
        if (m_axis.tvalid && m_axis.tready) begin
          m_axis.tvalid <= 1'b0;
        end
      end

      tx_shift      <= tx_shift_n;
      hold_data     <= hold_data_n;
      hold_valid    <= hold_valid_n;
      s_axis.tready <= ~hold_valid_n;
      if (tx_under_set) begin
        tx_underflow <= 1'b1;
      end

      spi_miso    <= cs_act ? tx_shift_n[DATA_W-1] : 1'b0;
      spi_miso_oe <= cs_act;
    end
  end

endmodule

// File: tb/tb_spi_slave2axis.sv
// Directed bench for spi_slave2axis: an SPI master model drives the bus,
// received bytes are checked by a scoreboard monitor on m_axis.
module tb_spi_slave2axis;

  localparam int unsigned S = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, rx_overflow, tx_underflow;

  spi_slave2axis_if m_if ();
  spi_slave2axis_if s_if ();

  spi_slave2axis #(.SYNC_STAGES(S)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .m_axis      (m_if),
    .s_axis      (s_if),
    .rx_overflow (rx_overflow),
    .tx_underflow(tx_underflow)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every m_axis handshake must match the next expected byte
  always @(negedge aclk) begin
    if (aresetn && m_if.tvalid && m_if.tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got 0x%0h expected none at %0t", m_if.tdata, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (m_if.tdata !== e) begin
          errors++;
          $display("FAIL rx_data: got 0x%0h expected 0x%0h at %0t", m_if.tdata, e, $time);
        end
      end
    end
  end

  // MISO must be quiet whenever it is not driven
  always @(negedge aclk) begin
    if (aresetn && !spi_miso_oe) begin
      checks++;
      if (spi_miso !== 1'b0) begin
        errors++;
        $display("FAIL miso_idle: got %b expected 0 at %0t", spi_miso, $time);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge aclk);
    #3;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    s_if.tvalid = 1'b0;
    wait_clk(3);
    aresetn = 1'b1;
    wait_clk(2);
  endtask

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_release();
    wait_clk(5);
    spi_cs_n = 1'b1;
    wait_clk(6);
  endtask

  // Mode 0 master: data set while SCLK low, both sides sample on the rise
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(5);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clk(5);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_s(input logic [7:0] d);
    int n;
    n = 0;
    s_if.tdata = d;
    s_if.tvalid = 1'b1;
    @(negedge aclk);
    while (!s_if.tready && n < 100) begin
      n++;
      @(negedge aclk);
    end
    chk("s_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge aclk);
    #1 s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(posedge aclk);
    end
    wait_clk(2);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;

    // Reset values
    wait_clk(3);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tdata", 32'(m_if.tdata), 32'h00);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_flags", {30'd0, rx_overflow, tx_underflow}, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1 chk("s_tready_after_rst", 32'(s_if.tready), 32'd1);

    // 1: RX stream with the TX side kept fed
    do_reset();
    s_if.tdata = 8'hC3;
    s_if.tvalid = 1'b1;
    wait_clk(3);
    cs_assert();
    exp_q.push_back(8'h01); spi_xfer(8'h01, 8, rx); chk("t1_miso0", 32'(rx), 32'hC3);
    exp_q.push_back(8'h34); spi_xfer(8'h34, 8, rx); chk("t1_miso1", 32'(rx), 32'hC3);
    exp_q.push_back(8'h12); spi_xfer(8'h12, 8, rx); chk("t1_miso2", 32'(rx), 32'hC3);
    cs_release();
    s_if.tvalid = 1'b0;
    wait_drain("t1_drain");
    chk("t1_flags", {30'd0, rx_overflow, tx_underflow}, 32'd0);

    // 2: TX stream with underflow on the third byte
    do_reset();
    send_s(8'hA5);
    cs_assert();
    send_s(8'h3C);
    exp_q.push_back(8'h11); spi_xfer(8'h11, 8, rx); chk("t2_tx0", 32'(rx), 32'hA5);
    wait_clk(5);
    chk("t2_underflow_b0", 32'(tx_underflow), 32'd0);
    exp_q.push_back(8'h22); spi_xfer(8'h22, 8, rx); chk("t2_tx1", 32'(rx), 32'h3C);
    wait_clk(5);
    chk("t2_underflow_b1", 32'(tx_underflow), 32'd1);
    exp_q.push_back(8'h33); spi_xfer(8'h33, 8, rx); chk("t2_tx2", 32'(rx), 32'h00);
    cs_release();
    wait_drain("t2_drain");

    // 3: RX backpressure, second byte dropped
    do_reset();
    m_if.tready = 1'b0;
    cs_assert();
    spi_xfer(8'h55, 8, rx);
    spi_xfer(8'hAA, 8, rx);
    cs_release();
    chk("t3_tvalid_held", 32'(m_if.tvalid), 32'd1);
    chk("t3_tdata_held", 32'(m_if.tdata), 32'h55);
    chk("t3_overflow", 32'(rx_overflow), 32'd1);
    exp_q.push_back(8'h55);
    m_if.tready = 1'b1;
    wait_clk(4);
    chk("t3_tvalid_clear", 32'(m_if.tvalid), 32'd0);
    wait_drain("t3_drain");

    // 4: aborted byte, then a full transfer with a fresh TX byte
    do_reset();
    send_s(8'h96);
    cs_assert();
    spi_xfer(8'hFF, 5, rx);
    chk("t4_partial_tx", 32'(rx), 32'h12);
    cs_release();
    chk("t4_no_output", 32'(m_if.tvalid), 32'd0);
    send_s(8'h69);
    cs_assert();
    exp_q.push_back(8'h81); spi_xfer(8'h81, 8, rx); chk("t4_tx", 32'(rx), 32'h69);
    cs_release();
    wait_drain("t4_drain");

    // 5: reset in the middle of a byte, CS kept low through reset
    do_reset();
    cs_assert();
    spi_xfer(8'hFF, 3, rx);
    chk("t5_pre_oe", 32'(spi_miso_oe), 32'd1);
    chk("t5_pre_underflow", 32'(tx_underflow), 32'd1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("t5_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("t5_tdata", 32'(m_if.tdata), 32'h00);
    chk("t5_s_tready", 32'(s_if.tready), 32'd0);
    chk("t5_miso", 32'(spi_miso), 32'd0);
    chk("t5_miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("t5_flags", {30'd0, rx_overflow, tx_underflow}, 32'd0);
    wait_clk(2);
    aresetn = 1'b1;
    wait_clk(6);
    exp_q.push_back(8'h5A); spi_xfer(8'h5A, 8, rx);
    cs_release();
    wait_drain("t5_drain");

    // 6: output enable follows CS through the synchronizer
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk);
      #3 spi_cs_n = 1'b0;
      repeat (S) @(posedge aclk);
      #1 chk("t6_oe_rise_early", 32'(spi_miso_oe), 32'd0);
      @(posedge aclk);
      #1 chk("t6_oe_rise", 32'(spi_miso_oe), 32'd1);
      wait_clk(4);
      spi_cs_n = 1'b1;
      repeat (S) @(posedge aclk);
      #1 chk("t6_oe_fall_early", 32'(spi_miso_oe), 32'd1);
      @(posedge aclk);
      #1 chk("t6_oe_fall", 32'(spi_miso_oe), 32'd0);
      chk("t6_miso_off", 32'(spi_miso), 32'd0);
      wait_clk(4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
